ssd_scan_ctrl: RTL and testbench
================================

// Module: ssd_scan_ctrl
// PURPOSE
//   Parametrised multiplexed seven-segment display driver. Scans DIGITS digit positions
//   in turn, decodes each nibble to segments, drives the decimal point and dims the display
//   with a 16-step duty control.
//   Sits between the datapath (packed nibble bus) and the display pads, in place of the
//   fixed 4-digit counter / mux / 3-8 decoder / BCD-7seg chain.
// PARAMETERS
//   DIGITS         4  number of digit positions, legal range 2..8
//   TICK_DIV       1  Clk cycles per sub-tick (>=1). One slot = 16 sub-ticks; one frame = DIGITS slots.
//   SEG_ACTIVE_LOW 0  1: every seg bit is inverted at the output register
//   DG_ACTIVE_LOW  0  1: every dg bit is inverted at the output register
// PORTS
//   Clk       in   1          system clock, rising edge
//   Aclr      in   1          asynchronous active-low reset
//   data_i    in   4*DIGITS   nibble k = data_i[4k+3:4k] is digit k; digit 0 is least significant
//   dp_i      in   DIGITS     decimal point per digit
//   load_i    in   1          request: copy data_i/dp_i into shadow at next frame boundary
//   hex_mode  in   1          1: glyphs 0-F; 0: BCD, nibbles A-F blank (segments a-g off)
//   bright_i  in   4          on-time in sub-ticks per slot, 0..15
//   seg       out  8          seg[0..6]=a..g, seg[7]=dp, registered
//   dg        out  DIGITS     one-hot digit enable, registered
//   frame_o   out  1          1-cycle pulse at frame boundary
// BEHAVIOUR
//   Reset (Aclr=0, async): tcnt, sub, idx, load-pending and shadow = 0; bright_q = 0; frame_o = 0;
//     seg and dg at inactive level (0, or all-1 when the polarity parameter is 1). Reset mid-slot
//     blanks immediately. First slot after release is idx 0.
//   Counters: tcnt 0..TICK_DIV-1. On tcnt wrap, sub 0..15 advances. On sub 15->0, idx advances
//     0..DIGITS-1 and wraps to 0.
//   Frame boundary: the cycle in which idx wraps DIGITS-1 -> 0. frame_o=1 in the following cycle.
//   Load handshake:
//     - load_i=1 sets pending.
//     - At a frame boundary with pending=1, or with load_i=1 in that same cycle, shadow <= data_i/dp_i
//       sampled in that cycle, and pending clears.
//     - Multiple loads within one frame: the last data present at the boundary wins.
//     - Display never changes content mid-frame.
//   Brightness: bright_q <= bright_i when tcnt=0 and sub=0 (slot start), held for the whole slot.
//   Drive: for the current slot, dg[idx] is active when sub < bright_q, otherwise every dg bit is inactive.
//     - seg shows the glyph of shadow nibble idx, with seg[7]=shadow dp[idx], while dg is active.
//     - seg is inactive while dg is inactive.
//     - Sub-tick 15 is always dark (anti-ghost guard). bright_q=0 means fully dark.
//   Latency: seg/dg are registered, so they reflect the counter state one Clk after it.
//   Glyphs (a-g, hex LSB=a):
//     0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 B:7C C:39 D:5E E:79 F:71
//   hex_mode is sampled combinationally for every slot (no shadow).
// CONFIGURATION
//   SSD_LZB_EN defined: leading-zero blanking.
//     - Digit k>0 is blanked (a-g off) when its shadow nibble and every nibble above it are 0.
//     - Digit 0 is never blanked. dp is still driven. dg timing is unchanged.
//   SSD_LZB_EN undefined: every digit shows its glyph; no blanking logic is built.
// TESTING (DIGITS=4, TICK_DIV=2: slot 32 cycles, frame 128 cycles, polarities 0, bright_i=15)
//   1 Aclr=0 at any time -> seg=00, dg=0, frame_o=0 within the same cycle;
//     after release, first active slot is dg=0001.
//   2 data_i=16'h1234, load pulse, dp_i=0 -> from next frame:
//     dg 0001/seg 66, 0010/4F, 0100/5B, 1000/06, repeating; frame_o every 128 cycles.
//   3 nibble 0=4'hA: hex_mode=1 -> seg 77; hex_mode=0 -> seg 00 while dg=0001; dp_i[0]=1 adds seg[7].
//   4 bright_i=4 -> dg active exactly 8 cycles per 32-cycle slot.
//     bright_i=0 -> dg never active; bright_i=15 -> 30 of 32 cycles.
//     A bright change mid-slot takes effect at the next slot.
//   5 load_i at cycle 50 of a frame with new data -> display unchanged until frame boundary.
//     load_i coincident with the boundary cycle -> applied at that boundary.
//   6 (SSD_LZB_EN) data 16'h0045 -> slots 3,2 seg=00, slot 1 seg=66, slot 0 seg=6D.
//     data 16'h0000 -> only slot 0 shows 3F.

Source files
------------

// File: rtl/ssd_scan_ctrl.sv
// Multiplexed seven-segment scan driver with shadowed frame-boundary loads and 16-step dimming.
// Define SSD_LZB_EN to build leading-zero blanking (digit 0 is never blanked).
module ssd_scan_ctrl #(
  parameter int DIGITS         = 4,
  parameter int TICK_DIV       = 1,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DG_ACTIVE_LOW  = 0
) (
  input  logic                  Clk,
  input  logic                  Aclr,
  input  logic [4*DIGITS-1:0]   data_i,
  input  logic [DIGITS-1:0]     dp_i,
  input  logic                  load_i,
  input  logic                  hex_mode,
  input  logic [3:0]            bright_i,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     dg,
  output logic                  frame_o
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IW = $clog2(DIGITS);
  localparam logic [TW-1:0]     TCNT_MAX = TW'(TICK_DIV - 1);
  localparam logic [IW-1:0]     IDX_MAX  = IW'(DIGITS - 1);
  localparam logic [7:0]        SEG_INV  = (SEG_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [DIGITS-1:0] DG_INV   = (DG_ACTIVE_LOW != 0) ? '1 : '0;

  logic [TW-1:0]       tcnt;
  logic [3:0]          sub;
  logic [IW-1:0]       idx;
  logic                pending;
  logic [4*DIGITS-1:0] shadow_data;
  logic [DIGITS-1:0]   shadow_dp;
  logic [3:0]          bright_q;

  logic                tick_wrap, sub_wrap, boundary, slot_start, active;
  logic [3:0]          eff_bright, nib;
  logic                dp_sel, blank_sel;
  logic [DIGITS-1:0]   lz_blank;
  logic [6:0]          glyph_bits;
  logic [7:0]          seg_d;
  logic [DIGITS-1:0]   dg_d;

  function automatic logic [6:0] glyph(input logic [3:0] n, input logic hex);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'h3F;  4'h1: g = 7'h06;  4'h2: g = 7'h5B;  4'h3: g = 7'h4F;
      4'h4: g = 7'h66;  4'h5: g = 7'h6D;  4'h6: g = 7'h7D;  4'h7: g = 7'h07;
      4'h8: g = 7'h7F;  4'h9: g = 7'h6F;  4'hA: g = 7'h77;  4'hB: g = 7'h7C;
      4'hC: g = 7'h39;  4'hD: g = 7'h5E;  4'hE: g = 7'h79;  default: g = 7'h71;
    endcase
    if (!hex && n > 4'h9) g = '0;
    return g;
  endfunction

  assign tick_wrap  = (tcnt == TCNT_MAX);
  assign sub_wrap   = tick_wrap && (sub == 4'hF);
  assign boundary   = sub_wrap && (idx == IDX_MAX);
  assign slot_start = (tcnt == '0) && (sub == '0);

  always_ff @(posedge Clk or negedge Aclr) begin
    if (!Aclr) begin
      tcnt        <= '0;
      sub         <= '0;
      idx         <= '0;
      pending     <= 1'b0;
      shadow_data <= '0;
      shadow_dp   <= '0;
      bright_q    <= '0;
    end else begin
      tcnt <= tick_wrap ? '0 : tcnt + 1'b1;
      if (tick_wrap) sub <= sub + 4'd1;
      if (sub_wrap)  idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
      if (slot_start) bright_q <= bright_i;
      if (boundary) begin
        if (pending || load_i) begin
          shadow_data <= data_i;
          shadow_dp   <= dp_i;
        end
        pending <= 1'b0;
      end else if (load_i) begin
        pending <= 1'b1;
      end
    end
  end

`ifdef SSD_LZB_EN
  always_comb begin
    logic zero_run;
    zero_run = 1'b1;
    lz_blank = '0;
    for (int unsigned k = DIGITS - 1; k >= 1; k--) begin
      zero_run    = zero_run && (shadow_data[4*k +: 4] == 4'h0);
      lz_blank[k] = zero_run;
    end
  end
`else
  always_comb lz_blank = '0;
`endif

  // bright_q only updates after the slot-start edge, so that first cycle takes bright_i directly
  always_comb begin
    eff_bright = slot_start ? bright_i : bright_q;
    active     = (sub < eff_bright) && (sub != 4'hF);
    nib        = '0;
    dp_sel     = 1'b0;
    blank_sel  = 1'b0;
    dg_d       = '0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (idx == IW'(k)) begin
        nib       = shadow_data[4*k +: 4];
        dp_sel    = shadow_dp[k];
        blank_sel = lz_blank[k];
        dg_d[k]   = active;
      end
    end
    glyph_bits = blank_sel ? '0 : glyph(nib, hex_mode);
    seg_d      = active ? {dp_sel, glyph_bits} : '0;
  end

  always_ff @(posedge Clk or negedge Aclr) begin
    if (!Aclr) begin
      seg     <= SEG_INV;
      dg      <= DG_INV;
      frame_o <= 1'b0;
    end else begin
      seg     <= seg_d ^ SEG_INV;
      dg      <= dg_d ^ DG_INV;
      frame_o <= boundary;
    end
  end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Scoreboard bench for ssd_scan_ctrl (DIGITS=4, TICK_DIV=2): frame-position model predicts every output cycle.
module tb_ssd_scan_ctrl;

  logic        Clk = 1'b0;
  logic        Aclr = 1'b0;
  logic [15:0] data_i = '0;
  logic [3:0]  dp_i = '0;
  logic        load_i = 1'b0;
  logic        hex_mode = 1'b1;
  logic [3:0]  bright_i = 4'd15;
  logic [7:0]  seg;
  logic [3:0]  dg;
  logic        frame_o;

  int n_checks = 0;
  int n_errors = 0;

  ssd_scan_ctrl #(.DIGITS(4), .TICK_DIV(2), .SEG_ACTIVE_LOW(0), .DG_ACTIVE_LOW(0)) dut (
    .Clk(Clk), .Aclr(Aclr), .data_i(data_i), .dp_i(dp_i), .load_i(load_i),
    .hex_mode(hex_mode), .bright_i(bright_i), .seg(seg), .dg(dg), .frame_o(frame_o)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] ref_glyph(input logic [3:0] n, input logic hex);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'h3F;  4'h1: g = 7'h06;  4'h2: g = 7'h5B;  4'h3: g = 7'h4F;
      4'h4: g = 7'h66;  4'h5: g = 7'h6D;  4'h6: g = 7'h7D;  4'h7: g = 7'h07;
      4'h8: g = 7'h7F;  4'h9: g = 7'h6F;  4'hA: g = 7'h77;  4'hB: g = 7'h7C;
      4'hC: g = 7'h39;  4'hD: g = 7'h5E;  4'hE: g = 7'h79;  default: g = 7'h71;
    endcase
    if (!hex && n > 4'h9) g = 7'h00;
    return g;
  endfunction

  // Model state: position is derived purely from cycles since reset release
  int unsigned mcyc = 0;
  logic [15:0] mdata = '0;
  logic [3:0]  mdp = '0;
  logic        mpend = 1'b0;
  logic [3:0]  mbright = '0;
  logic [12:0] sb[$];

  always @(posedge Clk or negedge Aclr) begin
    if (!Aclr) begin
      mcyc = 0; mdata = '0; mdp = '0; mpend = 1'b0; mbright = '0;
      sb.delete();
    end else begin
      int unsigned p, slot, st;
      logic act, blank;
      logic [3:0] nib;
      logic [6:0] g;
      logic [7:0] es;
      logic [3:0] ed;
      p    = mcyc % 128;
      slot = p / 32;
      st   = (p % 32) / 2;
      if (p % 32 == 0) mbright = bright_i;
      act  = (st < mbright) && (st != 15);
      nib  = mdata[slot*4 +: 4];
`ifdef SSD_LZB_EN
      blank = (slot > 0) && ((mdata >> (slot*4)) == 16'h0);
`else
      blank = 1'b0;
`endif
      g  = blank ? 7'h00 : ref_glyph(nib, hex_mode);
      es = act ? {mdp[slot], g} : 8'h00;
      ed = act ? (4'b0001 << slot) : 4'b0000;
      sb.push_back({(p == 127), ed, es});
      if (p == 127) begin
        if (mpend || load_i) begin mdata = data_i; mdp = dp_i; end
        mpend = 1'b0;
      end else if (load_i) begin
        mpend = 1'b1;
      end
      mcyc++;
    end
  end

  always @(negedge Clk) begin
    if (Aclr && sb.size() > 0) begin
      logic [12:0] e;
      e = sb.pop_front();
      check("scan", {19'h0, frame_o, dg, seg}, {19'h0, e});
    end
  end

  task automatic wait_pos(input int unsigned pos);
    bit found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge Clk);
      if (mcyc % 128 == pos) found = 1;
    end
    if (!found) check("wait_pos_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dp);
    data_i = d; dp_i = dp; load_i = 1'b1;
    @(negedge Clk);
    load_i = 1'b0;
  endtask

  task automatic measure_frame(output int act_cyc, output int frames);
    act_cyc = 0; frames = 0;
    wait_pos(0);
    repeat (128) begin
      @(negedge Clk);
      if (dg != 4'b0) act_cyc++;
      if (frame_o) frames++;
    end
  endtask

  initial begin
    int a, f;
    repeat (3) @(negedge Clk);
    check("rst_seg", {24'h0, seg}, 32'h0);
    check("rst_dg", {28'h0, dg}, 32'h0);
    check("rst_frame", {31'h0, frame_o}, 32'h0);
    Aclr = 1'b1;
    @(negedge Clk);
    check("first_dg", {28'h0, dg}, 32'h1);

    wait_pos(10);
    do_load(16'h1234, 4'h0);
    wait_pos(0);
    @(negedge Clk);
    check("d0_seg", {24'h0, seg}, 32'h66);
    measure_frame(a, f);
    check("frame_count", f, 1);
    check("duty15", a, 120);

    do_load(16'h123A, 4'b0001);
    wait_pos(0);
    @(negedge Clk);
    check("hexA_seg", {24'h0, seg}, 32'hF7);
    hex_mode = 1'b0;
    wait_pos(0);
    @(negedge Clk);
    check("bcdA_seg", {24'h0, seg}, 32'h80);
    hex_mode = 1'b1;

    bright_i = 4'd4;
    measure_frame(a, f);
    check("duty4", a, 32);
    bright_i = 4'd0;
    measure_frame(a, f);
    check("duty0", a, 0);
    wait_pos(40);
    bright_i = 4'd6;
    wait_pos(0);
    bright_i = 4'd15;

    wait_pos(50);
    do_load(16'h5678, 4'b0100);
    wait_pos(127);
    data_i = 16'h9ABC; load_i = 1'b1;
    @(negedge Clk);
    load_i = 1'b0;
    wait_pos(0);
    wait_pos(127);
    data_i = 16'hFEDC; dp_i = 4'b1010; load_i = 1'b1;
    @(negedge Clk);
    load_i = 1'b0;
    wait_pos(10);
    do_load(16'h1111, 4'h0);
    wait_pos(30);
    data_i = 16'h2222;
    wait_pos(60);
    do_load(16'h3333, 4'hF);
    wait_pos(80);
    data_i = 16'h4444;

    wait_pos(5);
    do_load(16'h0045, 4'h0);
    wait_pos(5);
    do_load(16'h0000, 4'h1);
    wait_pos(5);
    do_load(16'h0908, 4'h0);
    wait_pos(0);

    wait_pos(70);
    @(posedge Clk);
    #2 Aclr = 1'b0;
    #1;
    check("async_seg", {24'h0, seg}, 32'h0);
    check("async_dg", {28'h0, dg}, 32'h0);
    check("async_frame", {31'h0, frame_o}, 32'h0);
    @(negedge Clk);
    data_i = 16'h0007;
    Aclr = 1'b1;
    @(negedge Clk);
    check("rel_dg", {28'h0, dg}, 32'h1);
    check("rel_seg", {24'h0, seg}, 32'h3F);
    measure_frame(a, f);
    check("frame_after_rst", f, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
